// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-pin bundle for sram_port_arbiter.
// slave = arbiter view, master = requesters plus SRAM macro.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ-1:0]        i_req_wen;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
    logic [NUM_REQ*DATA_W-1:0] i_req_bit_mask;
    logic [NUM_REQ-1:0]        i_req_lock;
    logic [NUM_REQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]         o_rsp_rdata;
    logic                      o_sram_cen;
    logic                      o_sram_wen;
    logic [ADDR_W-1:0]         o_sram_addr;
    logic [DATA_W-1:0]         o_sram_wdata;
    logic [DATA_W-1:0]         o_sram_bit_mask;
    logic [DATA_W-1:0]         i_sram_rdata;

    modport slave (
        input  i_req_valid,
        input  i_req_wen,
        input  i_req_addr,
        input  i_req_wdata,
        input  i_req_bit_mask,
        input  i_req_lock,
        input  i_sram_rdata,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_rdata,
        output o_sram_cen,
        output o_sram_wen,
        output o_sram_addr,
        output o_sram_wdata,
        output o_sram_bit_mask
    );

    modport master (
        output i_req_valid,
        output i_req_wen,
        output i_req_addr,
        output i_req_wdata,
        output i_req_bit_mask,
        output i_req_lock,
        output i_sram_rdata,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_rdata,
        input  o_sram_cen,
        input  o_sram_wen,
        input  o_sram_addr,
        input  o_sram_wdata,
        input  o_sram_bit_mask
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one sram_1024x64 between NUM_REQ
// requesters; lock bursts, registered SRAM pins, 2-cycle read return.
module sram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sram_port_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_W   = (ID_W+1)'(NUM_REQ);

    // Arbitration state
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic            last_vld_q;
    logic            last_vld_d;

    // Command stage S1 (drives the SRAM pins)
    logic              cen_q;
    logic              cen_d;
    logic              wen_q;
    logic              wen_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] mask_d;
    logic [ID_W-1:0]   tag_id_q;
    logic [ID_W-1:0]   tag_id_d;
    logic              tag_rd_q;
    logic              tag_rd_d;

    // Response stage S2
    logic            rsp_vld_q;
    logic            rsp_vld_d;
    logic [ID_W-1:0] rsp_id_q;
    logic [ID_W-1:0] rsp_id_d;

    // Combinational arbitration results
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W:0]      pos;
    logic               lock_hold;

    // Selected requester command
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_mask;

    // Winner search: first valid at or after rr_ptr, unless the owner holds lock
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        pos       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (pos >= NUM_W) begin
                pos = pos - NUM_W;
            end
            if (bus.i_req_valid[pos[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = pos[ID_W-1:0];
            end
        end
        lock_hold = last_vld_q
                  & bus.i_req_valid[last_q]
                  & bus.i_req_lock[last_q];
        if (lock_hold) begin
            grant_vld = 1'b1;
            grant_id  = last_q;
        end
    end

    // One-hot ready for the winner; forced low while reset is asserted
    always_comb begin
        grant_oh = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            grant_oh[r] = grant_vld && (grant_id == ID_W'(r));
        end
    end

    assign bus.o_req_ready = grant_oh & {NUM_REQ{i_rst_n}};

    // Mux the winning requester's command fields
    always_comb begin
        sel_wen   = bus.i_req_wen[grant_id];
        sel_addr  = bus.i_req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        sel_wdata = bus.i_req_wdata[int'(grant_id)*DATA_W +: DATA_W];
        sel_mask  = bus.i_req_bit_mask[int'(grant_id)*DATA_W +: DATA_W];
    end

    // Round-robin pointer and last-granted owner advance on every handshake
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (grant_vld) begin
            if (grant_id == LAST_ID) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id + 1'b1;
            end
            last_d     = grant_id;
            last_vld_d = 1'b1;
        end
    end

    // S1 next: load command on handshake; idle keeps addr/wdata to avoid toggling
    always_comb begin
        cen_d    = 1'b0;
        wen_d    = 1'b0;
        mask_d   = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag_id_d = tag_id_q;
        tag_rd_d = 1'b0;
        if (grant_vld) begin
            cen_d    = 1'b1;
            wen_d    = sel_wen;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            mask_d   = sel_wen ? sel_mask : '0;
            tag_id_d = grant_id;
            tag_rd_d = ~sel_wen;
        end
    end

    // S2 next: a read in S1 becomes a response one cycle later
    always_comb begin
        rsp_vld_d = cen_q & tag_rd_q;
        rsp_id_d  = tag_id_q;
    end

    // Arbitration state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q   <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

    // S1 command registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cen_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            tag_id_q <= '0;
            tag_rd_q <= 1'b0;
        end else begin
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            tag_id_q <= tag_id_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // S2 response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    // Decode S2 into the one-hot response strobe
    always_comb begin
        bus.o_rsp_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.o_rsp_valid[r] = rsp_vld_q && (rsp_id_q == ID_W'(r));
        end
    end

    assign bus.o_rsp_rdata     = bus.i_sram_rdata;
    assign bus.o_sram_cen      = cen_q;
    assign bus.o_sram_wen      = wen_q;
    assign bus.o_sram_addr     = addr_q;
    assign bus.o_sram_wdata    = wdata_q;
    assign bus.o_sram_bit_mask = mask_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table, corner sequences and
// randomized traffic against a grant-order reference model.
module tb_sram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Behavioural sram_1024x64 with a preload port
    logic [DW-1:0] mem [0:1023];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.o_sram_cen) begin
            if (bus.o_sram_wen) begin
                mem[bus.o_sram_addr] <= (mem[bus.o_sram_addr] & ~bus.o_sram_bit_mask)
                                      | (bus.o_sram_wdata & bus.o_sram_bit_mask);
            end else begin
                bus.i_sram_rdata <= mem[bus.o_sram_addr];
            end
        end
    end

    // Reference model: memory in grant order, responses due 2 cycles later
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] lock;
        logic [N-1:0] exp_rdy;
    } vec_t;

    logic [DW-1:0] ref_mem [0:1023];
    rsp_t          q[$];
    vec_t          tbl[18];
    int            rr_m;
    int            owner_m;
    int            cyc;
    logic          exp_cen;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_mask;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        logic [31:0] u;
        u = 32'(i);
        if (i == 5) return 64'hDEADBEEF_CAFEF00D;
        if (i == 1023) return 64'h0;
        return {u * 32'h9E3779B1, ~u};
    endfunction

    function automatic int model_winner();
        int r;
        if (owner_m >= 0 && bus.i_req_valid[owner_m] && bus.i_req_lock[owner_m]) begin
            return owner_m;
        end
        for (int k = 0; k < N; k++) begin
            r = (rr_m + k) % N;
            if (bus.i_req_valid[r]) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rr_m    = 0;
        owner_m = -1;
        exp_cen = 1'b0;
        q.delete();
    endtask

    task automatic model_check();
        int w;
        logic [N-1:0] er;
        w  = model_winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("ready", 64'(bus.o_req_ready), 64'(er));
        if (q.size() > 0 && q[0].due == cyc) begin
            er = '0;
            er[q[0].id] = 1'b1;
            chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(er));
            chk("rsp_rdata", bus.o_rsp_rdata, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", 64'(bus.o_rsp_valid), 64'h0);
        end
        chk("sram_cen", 64'(bus.o_sram_cen), 64'(exp_cen));
        if (exp_cen) begin
            chk("sram_wen", 64'(bus.o_sram_wen), 64'(exp_wen));
            chk("sram_addr", 64'(bus.o_sram_addr), 64'(exp_addr));
            chk("sram_mask", bus.o_sram_bit_mask, exp_mask);
        end
    endtask

    task automatic model_edge();
        int w;
        int a;
        rsp_t e;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        w = model_winner();
        exp_cen = (w >= 0);
        if (w >= 0) begin
            a = int'(bus.i_req_addr[w*AW +: AW]);
            d = bus.i_req_wdata[w*DW +: DW];
            m = bus.i_req_bit_mask[w*DW +: DW];
            exp_wen  = bus.i_req_wen[w];
            exp_addr = AW'(a);
            exp_mask = exp_wen ? m : '0;
            if (exp_wen) begin
                ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            end else begin
                e.due  = cyc + 2;
                e.id   = w;
                e.data = ref_mem[a];
                q.push_back(e);
            end
            rr_m    = (w + 1) % N;
            owner_m = w;
        end
    endtask

    task automatic tick(input bit use_tbl, input logic [N-1:0] tbl_rdy);
        @(negedge clk);
        if (use_tbl) chk("tbl_ready", 64'(bus.o_req_ready), 64'(tbl_rdy));
        model_check();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drv(input int r, input bit v, input bit w, input int a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m, input bit lk);
        bus.i_req_valid[r]               = v;
        bus.i_req_wen[r]                 = w;
        bus.i_req_addr[r*AW +: AW]       = AW'(a);
        bus.i_req_wdata[r*DW +: DW]      = d;
        bus.i_req_bit_mask[r*DW +: DW]   = m;
        bus.i_req_lock[r]                = lk;
    endtask

    task automatic clear_inputs();
        bus.i_req_valid    = '0;
        bus.i_req_wen      = '0;
        bus.i_req_addr     = '0;
        bus.i_req_wdata    = '0;
        bus.i_req_bit_mask = '0;
        bus.i_req_lock     = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(bus.o_req_ready), 64'h0);
        chk({tag, "_rsp"}, 64'(bus.o_rsp_valid), 64'h0);
        chk({tag, "_cen"}, 64'(bus.o_sram_cen), 64'h0);
        chk({tag, "_wen"}, 64'(bus.o_sram_wen), 64'h0);
        chk({tag, "_addr"}, 64'(bus.o_sram_addr), 64'h0);
        chk({tag, "_wdata"}, bus.o_sram_wdata, 64'h0);
        chk({tag, "_mask"}, bus.o_sram_bit_mask, 64'h0);
    endtask

    initial begin
        cyc = 0;
        clear_inputs();
        model_reset();

        tbl[0]  = '{3'b111, 3'b000, 3'b001};
        tbl[1]  = '{3'b111, 3'b000, 3'b010};
        tbl[2]  = '{3'b111, 3'b000, 3'b100};
        tbl[3]  = '{3'b111, 3'b000, 3'b001};
        tbl[4]  = '{3'b111, 3'b000, 3'b010};
        tbl[5]  = '{3'b111, 3'b100, 3'b100};
        tbl[6]  = '{3'b111, 3'b100, 3'b100};
        tbl[7]  = '{3'b111, 3'b100, 3'b100};
        tbl[8]  = '{3'b111, 3'b100, 3'b100};
        tbl[9]  = '{3'b011, 3'b000, 3'b001};
        tbl[10] = '{3'b111, 3'b100, 3'b010};
        tbl[11] = '{3'b111, 3'b100, 3'b100};
        tbl[12] = '{3'b111, 3'b100, 3'b100};
        tbl[13] = '{3'b111, 3'b000, 3'b001};
        tbl[14] = '{3'b100, 3'b000, 3'b100};
        tbl[15] = '{3'b010, 3'b000, 3'b010};
        tbl[16] = '{3'b001, 3'b010, 3'b001};
        tbl[17] = '{3'b000, 3'b000, 3'b000};

        // Preload memory while held in reset
        pre_we = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            pre_addr   = AW'(i);
            pre_data   = init_val(i);
            ref_mem[i] = init_val(i);
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;

        // Reset state, with requests pending
        bus.i_req_valid = 3'b111;
        #1;
        chk_all_zero("reset");
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Arbitration vector table: contention, lock burst, release, single requester
        for (int i = 0; i < 18; i++) begin
            for (int r = 0; r < N; r++) begin
                drv(r, tbl[i].valid[r], 1'b0, 64 + i*4 + r, '0, '1, tbl[i].lock[r]);
            end
            tick(1'b1, tbl[i].exp_rdy);
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) tick(1'b0, '0);

        // Read latency: req1 reads 0x005
        drv(1, 1'b1, 1'b0, 5, '0, '1, 1'b0);
        tick(1'b0, '0);
        clear_inputs();
        chk("lat_t1", 64'(bus.o_rsp_valid), 64'h0);
        tick(1'b0, '0);
        chk("lat_t2_valid", 64'(bus.o_rsp_valid), 64'(3'b010));
        chk("lat_t2_data", bus.o_rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        tick(1'b0, '0);
        chk("lat_t3", 64'(bus.o_rsp_valid), 64'h0);

        // Masked write then read of 0x3FF
        drv(0, 1'b1, 1'b1, 10'h3FF, '1, 64'h0000_0000_FFFF_FFFF, 1'b0);
        tick(1'b0, '0);
        drv(0, 1'b1, 1'b0, 10'h3FF, '0, '1, 1'b0);
        tick(1'b0, '0);
        clear_inputs();
        chk("wr_no_rsp", 64'(bus.o_rsp_valid), 64'h0);
        tick(1'b0, '0);
        chk("raw_valid", 64'(bus.o_rsp_valid), 64'(3'b001));
        chk("raw_data", bus.o_rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        tick(1'b0, '0);

        // Idle SRAM pins after a write to 0x123
        drv(2, 1'b1, 1'b1, 10'h123, 64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00, 1'b0);
        tick(1'b0, '0);
        clear_inputs();
        chk("wr_cen", 64'(bus.o_sram_cen), 64'h1);
        chk("wr_mask", bus.o_sram_bit_mask, 64'hFF00_FF00_FF00_FF00);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0);
            chk("idle_cen", 64'(bus.o_sram_cen), 64'h0);
            chk("idle_addr", 64'(bus.o_sram_addr), 64'h123);
            chk("idle_mask", bus.o_sram_bit_mask, 64'h0);
        end

        // Reset one cycle after a read handshake
        drv(1, 1'b1, 1'b0, 10'h040, '0, '1, 1'b0);
        tick(1'b0, '0);
        clear_inputs();
        drv(0, 1'b1, 1'b0, 10'h041, '0, '1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) drv(r, 1'b1, 1'b0, 10'h050 + r, '0, '1, 1'b0);
        tick(1'b1, 3'b001);
        clear_inputs();
        chk("post_rst_rsp", 64'(bus.o_rsp_valid), 64'h0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                drv(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 15)), {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 2) == 0);
            end
            tick(1'b0, '0);
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) tick(1'b0, '0);
        chk("queue_drained", 64'(q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter that shares one `sram_1024x64` instance between `NUM_REQ` requesters in the Octree datapath, e.g. traversal engine, loader DMA and result writeback. It accepts single-word read/write commands on a valid/ready handshake and registers the winning command onto the SRAM pins. It tracks each read through a two-stage tag pipeline and returns read data to the originating requester with fixed latency. Throughput is one SRAM access per cycle.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 10: SRAM word address width.
- `DATA_W`, 64: SRAM data width.
- `i_clk`  in  1  clock; the SRAM shares this clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  NUM_REQ  command valid, one bit per requester.
- `o_req_ready`  out  NUM_REQ  command accepted this cycle; one-hot or zero.
- `i_req_wen`  in  NUM_REQ  1 = write, 0 = read.
- `i_req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester r at `[r*ADDR_W +: ADDR_W]`.
- `i_req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `i_req_bit_mask`  in  NUM_REQ*DATA_W  packed write masks; 1 = bit written.
- `i_req_lock`  in  NUM_REQ  while set, the current owner keeps priority (bursts).
- `o_rsp_valid`  out  NUM_REQ  read data valid, one-hot; no backpressure.
- `o_rsp_rdata`  out  DATA_W  read data, shared by all requesters.
- `o_sram_cen`  out  1  SRAM enable, active-high.
- `o_sram_wen`  out  1  SRAM write enable, active-high.
- `o_sram_addr`  out  ADDR_W  SRAM address.
- `o_sram_wdata`  out  DATA_W  SRAM write data.
- `o_sram_bit_mask`  out  DATA_W  SRAM write mask.
- `i_sram_rdata`  in  DATA_W  SRAM read data, valid the cycle after the macro samples a read.

## Operation
- **Arbitration (combinational):**
  - The winner is the first valid requester at or after `rr_ptr`, searching cyclically.
  - Lock override: if the last-granted requester L has `i_req_valid[L] & i_req_lock[L]`, L wins regardless of `rr_ptr`.
  - `o_req_ready[w]` = 1 for the winner only. Ready may depend on valid; requesters must not make valid depend on ready.
- **Handshake:** `valid & ready` on requester w at the rising edge ends cycle T. On that edge:
  - Command stage S1 loads cen=1, wen, addr, wdata, mask and tag {w, is_read}.
  - `rr_ptr` ← (w+1) mod NUM_REQ.
  - The last-granted register ← w.
- **No handshake:** S1 loads cen=0, wen=0, mask=0. addr and wdata hold their previous values (no toggling).
- **Read masks:** mask is forced to 0 on reads.
- **SRAM outputs:** driven directly from S1 registers; no combinational path from requester inputs to SRAM pins.
- **Response stage S2:** loads {valid = S1.cen & S1.is_read, id}. `o_rsp_valid[id]` = S2.valid, and `o_rsp_rdata` = `i_sram_rdata` passed through.
- **Writes** produce no response.
- **Ordering:** responses return in grant order; there is at most one response per cycle.
- **Read-after-write:** a read granted the cycle after a write to the same address returns the new data. This follows from SRAM order; no bypass is needed.
- **Lock release:** lock is released when the owner drops valid or lock. Arbitration then proceeds from `rr_ptr`.

## Timing
- **Reset values:**
  - `o_req_ready` 0.
  - `o_rsp_valid` 0.
  - `o_sram_cen`, `o_sram_wen` 0.
  - addr, wdata, mask 0.
  - `rr_ptr` 0.
  - Last-granted = 0 with its lock qualifier cleared.
- `o_rsp_rdata` is don't-care whenever `o_rsp_valid` is 0.
- **Read latency:** handshake edge ends T; macro samples at the edge ending T+1; `o_rsp_valid` is high during T+2. Latency is 2 cycles.
- **Throughput:** back-to-back accepts every cycle, with responses back-to-back in T+2, T+3, …
- **Reset mid-operation:** S1 and S2 clear immediately. In-flight reads are dropped and no `o_rsp_valid` is issued for them. In-flight writes are not guaranteed.
- **Single requester:** a lone valid requester is granted every cycle regardless of `rr_ptr`.
- **Simultaneous lock:** simultaneous lock on a non-owner has no effect until that requester becomes owner.

## Test plan
- **Read latency:**
  - Stimulus: preload addr 0x005 = 0xDEADBEEF_CAFEF00D. Req1 reads 0x005, handshake at cycle 10.
  - Required response: `o_rsp_valid` = 3'b010 at cycle 12 only, `o_rsp_rdata` = 0xDEADBEEF_CAFEF00D.
- **Three-way contention:**
  - Stimulus: all 3 hold valid reads from reset.
  - Required response: grants 0,1,2,0,1,2; responses follow the same order 2 cycles later; one grant per cycle.
- **Lock burst:**
  - Stimulus: req2 raises lock for 4 reads while req0 and req1 are valid.
  - Required response: req2 is granted 4 consecutive cycles; then req0, req1.
- **Masked write then read:**
  - Stimulus: write 0x3FF data all-ones, mask 0x0000_0000_FFFF_FFFF over prior 0. Read 0x3FF on the next cycle.
  - Required response: read returns 0x0000_0000_FFFF_FFFF; the write produces no `o_rsp_valid`.
- **Reset mid-flight:**
  - Stimulus: assert `i_rst_n` = 0 one cycle after a read handshake.
  - Required response: all outputs 0 asynchronously; no response after reset release. The first post-reset grant goes to req0.
- **Idle SRAM pins:**
  - Stimulus: no valid for 5 cycles after a write to 0x123.
  - Required response: `o_sram_cen` = 0, `o_sram_addr` stays 0x123, mask 0.
